mem_control: RTL and testbench
==============================

Name: mem_control

Overview:
- Decodes RISC-V load/store instructions plus the effective address into per-target enables:
  - Data memory byte-write mask
  - Instruction memory byte-write mask
  - IO transmit byte mask
  - IO receive strobe
- Sits in the execute/memory stage between the ALU address result and the memory/IO blocks.
- Decode is combinational. A small clocked block keeps a sticky misalignment error flag.

Parameters:
- None. Opcode and funct3 encodings come from the shared opcode package.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset (asserted when 0).
- opcode  input  7  instruction opcode.
- Funct3  input  3  instruction funct3.
- A  input  32  effective byte address.
- Err_clear  input  1  synchronous clear of Err_sticky.
- Dmem_enable  output  4  data-memory byte write enables.
- Imem_enable  output  4  instruction-memory byte write enables.
- Io_trans  output  4  IO write byte enables.
- Io_recv  output  1  IO read strobe.
- Misaligned  output  1  current access is misaligned (combinational).
- Err_sticky  output  1  registered; set when any misaligned access is seen.

Behaviour:
- Encodings:
  - OPC_LOAD = 7'b0000011; OPC_STORE = 7'b0100011.
  - Loads: LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - Stores: SB=000, SH=001, SW=010.
- Region decode from the address:
  - io = A[31].
  - dmem = ~A[31] & A[28].
  - imem = ~A[31] & A[29].
  - dmem and imem may both be true (e.g. 0x3xxxxxxx).
- Store byte mask, with off = A[1:0]:
  - SB: 4'b0001 << off.
  - SH: 4'b0011 << off.
  - SW: 4'b1111.
  - Any other store funct3: mask = 0.
- Misaligned = 1 when:
  - a store or valid load with LH/LHU/SH has A[0]=1, or
  - a store or valid load with LW/SW has A[1:0]!=0.
  - When Misaligned=1, all enables and Io_recv are 0.
- Store (opcode == OPC_STORE, aligned):
  - Dmem_enable = mask if dmem, else 0.
  - Imem_enable = mask if imem, else 0.
  - Io_trans = 4'b1111 if io and mask != 0, else 0. IO writes are always full-word regardless of size.
  - Io_recv = 0.
- Load (opcode == OPC_LOAD, valid funct3, aligned):
  - All write masks = 0.
  - Io_recv = io. Memory reads are unconditional and need no enable.
- Any other opcode, or a load with invalid funct3: all outputs 0, Misaligned = 0.
- No X on outputs for known inputs. Outputs settle within the same cycle as the inputs (zero latency).
- Err_sticky:
  - Async reset to 0 when Reset is low.
  - On a rising Clock edge: if Err_clear, becomes 0; else if Misaligned, becomes 1; otherwise holds.
  - Err_clear has priority over a simultaneous Misaligned.
- Reset does not affect the combinational outputs.

Optional Feature:
- Macro MEMCTRL_OUTREG_EN.
- Defined: Dmem_enable, Imem_enable, Io_trans, Io_recv and Misaligned are registered on Clock, giving exactly one cycle of latency. All of them async-reset to 0.
- Undefined: all of those outputs are purely combinational as described above.
- Err_sticky behaves identically in both builds, and is always fed from the combinational Misaligned.

Decomposition:
- Shared package holds:
  - OPC_* and FNC_* constants.
  - Region-bit positions: IO_BIT=31, DMEM_BIT=28, IMEM_BIT=29.
- One natural sub-module: mem_byte_mask. It maps Funct3 + A[1:0] to a 4-bit mask and a misaligned flag.

Test Plan:
- LB at A=0x80000000 → Io_recv=1, all masks 0. LH at A=0x10000000 → all outputs 0.
- LW at 0x80000000 → Io_recv=1. LBU/LHU at 0x10000000 → all 0.
- SB at 0x80000004 → Io_trans=1111, Dmem/Imem=0, Io_recv=0.
- SB at 0x10000003 → Dmem_enable=1000. SH at 0x10000002 → Dmem_enable=1100.
- SW at 0x30000000 → Dmem_enable=1111 and Imem_enable=1111, Io_trans=0.
- SW at 0x10000002 → Misaligned=1, all enables 0, Err_sticky=1 after the next edge. Err_clear=1 → Err_sticky=0 next edge. Reset low mid-run → Err_sticky=0 immediately.

Source files
------------

// File: rtl/mem_control_pkg.sv
// Shared opcode/funct3 encodings and address region bit positions for mem_control.
package mem_control_pkg;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;
  localparam logic [2:0] FNC_SB  = 3'b000;
  localparam logic [2:0] FNC_SH  = 3'b001;
  localparam logic [2:0] FNC_SW  = 3'b010;

  localparam int IO_BIT   = 31;
  localparam int DMEM_BIT = 28;
  localparam int IMEM_BIT = 29;
endpackage

// File: rtl/mem_control_byte_mask.sv
// Maps funct3 and the low address bits to a byte-write mask, a funct3-valid
// flag and a size-alignment fault flag for loads and stores.
module mem_byte_mask
  import mem_control_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic [1:0] i_off,
  input  logic       i_is_store,
  output logic [3:0] o_mask,
  output logic       o_valid,
  output logic       o_misaligned
);

  // Size decode; the unsigned load encodings are not stores and so are invalid there.
  always_comb begin
    o_mask       = 4'b0000;
    o_valid      = 1'b0;
    o_misaligned = 1'b0;
    case (i_funct3)
      FNC_SB: begin
        o_mask  = 4'b0001 << i_off;
        o_valid = 1'b1;
      end
      FNC_SH: begin
        o_mask       = 4'b0011 << i_off;
        o_valid      = 1'b1;
        o_misaligned = i_off[0];
      end
      FNC_SW: begin
        o_mask       = 4'b1111;
        o_valid      = 1'b1;
        o_misaligned = (i_off != 2'b00);
      end
      FNC_LBU: begin
        o_valid = ~i_is_store;
      end
      FNC_LHU: begin
        o_valid      = ~i_is_store;
        o_misaligned = ~i_is_store & i_off[0];
      end
      default: begin
        o_mask       = 4'b0000;
        o_valid      = 1'b0;
        o_misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_control.sv
// Load/store target-enable decoder with sticky misalignment flag.
// Define MEMCTRL_OUTREG_EN to register the decode outputs (one cycle latency).
module mem_control
  import mem_control_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  Funct3,
  input  logic [31:0] A,
  input  logic        Err_clear,
  output logic [3:0]  Dmem_enable,
  output logic [3:0]  Imem_enable,
  output logic [3:0]  Io_trans,
  output logic        Io_recv,
  output logic        Misaligned,
  output logic        Err_sticky
);

  logic       w_is_load;
  logic       w_is_store;
  logic [3:0] w_mask;
  logic       w_f3_valid;
  logic       w_size_mis;
  logic       w_io;
  logic       w_dmem_rgn;
  logic       w_imem_rgn;
  logic [3:0] w_dmem;
  logic [3:0] w_imem;
  logic [3:0] w_io_trans;
  logic       w_io_recv;
  logic       w_mis;
  logic       r_err_sticky;

  assign w_is_load  = (opcode == OPC_LOAD);
  assign w_is_store = (opcode == OPC_STORE);
  assign w_io       = A[IO_BIT];
  assign w_dmem_rgn = ~A[IO_BIT] & A[DMEM_BIT];
  assign w_imem_rgn = ~A[IO_BIT] & A[IMEM_BIT];

  mem_byte_mask u_byte_mask (
    .i_funct3     (Funct3),
    .i_off        (A[1:0]),
    .i_is_store   (w_is_store),
    .o_mask       (w_mask),
    .o_valid      (w_f3_valid),
    .o_misaligned (w_size_mis)
  );

  // Target decode; a misaligned access suppresses every enable.
  always_comb begin
    w_dmem     = 4'b0000;
    w_imem     = 4'b0000;
    w_io_trans = 4'b0000;
    w_io_recv  = 1'b0;
    w_mis      = 1'b0;
    if ((w_is_load | w_is_store) & w_f3_valid & w_size_mis) begin
      w_mis = 1'b1;
    end else if (w_is_store & w_f3_valid) begin
      w_dmem     = w_dmem_rgn ? w_mask : 4'b0000;
      w_imem     = w_imem_rgn ? w_mask : 4'b0000;
      w_io_trans = (w_io && (w_mask != 4'b0000)) ? 4'b1111 : 4'b0000;
    end else if (w_is_load & w_f3_valid) begin
      w_io_recv = w_io;
    end else begin
      w_mis = 1'b0;
    end
  end

`ifdef MEMCTRL_OUTREG_EN
  logic [3:0] r_dmem;
  logic [3:0] r_imem;
  logic [3:0] r_io_trans;
  logic       r_io_recv;
  logic       r_mis;

  // Output pipeline stage.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_dmem     <= 4'b0000;
      r_imem     <= 4'b0000;
      r_io_trans <= 4'b0000;
      r_io_recv  <= 1'b0;
      r_mis      <= 1'b0;
    end else begin
      r_dmem     <= w_dmem;
      r_imem     <= w_imem;
      r_io_trans <= w_io_trans;
      r_io_recv  <= w_io_recv;
      r_mis      <= w_mis;
    end
  end

  assign Dmem_enable = r_dmem;
  assign Imem_enable = r_imem;
  assign Io_trans    = r_io_trans;
  assign Io_recv     = r_io_recv;
  assign Misaligned  = r_mis;
`else
  assign Dmem_enable = w_dmem;
  assign Imem_enable = w_imem;
  assign Io_trans    = w_io_trans;
  assign Io_recv     = w_io_recv;
  assign Misaligned  = w_mis;
`endif

  // Sticky error: clear wins over a simultaneous misaligned access.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_err_sticky <= 1'b0;
    end else if (Err_clear) begin
      r_err_sticky <= 1'b0;
    end else if (w_mis) begin
      r_err_sticky <= 1'b1;
    end else begin
      r_err_sticky <= r_err_sticky;
    end
  end

  assign Err_sticky = r_err_sticky;

endmodule

// File: tb/tb_mem_control.sv
// Scoreboard bench for mem_control: expected decode pushed at drive time,
// popped and compared once the outputs are valid (latency follows MEMCTRL_OUTREG_EN).
module tb_mem_control;
  localparam logic [6:0] T_LOAD  = 7'b0000011;
  localparam logic [6:0] T_STORE = 7'b0100011;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic        err_clear;
  logic [3:0]  dmem_en;
  logic [3:0]  imem_en;
  logic [3:0]  io_trans;
  logic        io_recv;
  logic        misaligned;
  logic        err_sticky;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [13:0] exp;
  } sb_t;
  sb_t sb_q[$];

  mem_control dut (
    .Clock       (clk),
    .Reset       (rst_n),
    .opcode      (opcode),
    .Funct3      (funct3),
    .A           (addr),
    .Err_clear   (err_clear),
    .Dmem_enable (dmem_en),
    .Imem_enable (imem_en),
    .Io_trans    (io_trans),
    .Io_recv     (io_recv),
    .Misaligned  (misaligned),
    .Err_sticky  (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode: {dmem, imem, io_trans, io_recv, misaligned}
  function automatic logic [13:0] model(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a);
    logic [1:0] off;
    logic [7:0] m8;
    logic [3:0] mask;
    logic       mis;
    logic       io, dm, im, lvalid;
    logic [3:0] d, i, t;
    logic       r;
    off = a[1:0];
    io  = a[31];
    dm  = ~a[31] & a[28];
    im  = ~a[31] & a[29];
    d = 4'd0; i = 4'd0; t = 4'd0; r = 1'b0; mis = 1'b0; mask = 4'd0;
    if (op == T_STORE) begin
      case (f3)
        3'd0: begin m8 = 8'd1 << off; mask = m8[3:0]; end
        3'd1: begin m8 = 8'd3 << off; mask = m8[3:0]; mis = off[0]; end
        3'd2: begin mask = 4'hF; mis = (off != 2'd0); end
        default: mask = 4'd0;
      endcase
      if (!mis) begin
        d = dm ? mask : 4'd0;
        i = im ? mask : 4'd0;
        t = (io && mask != 4'd0) ? 4'hF : 4'd0;
      end
    end else if (op == T_LOAD) begin
      lvalid = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      if (lvalid) begin
        mis = (((f3 == 3'd1) || (f3 == 3'd5)) && off[0]) || ((f3 == 3'd2) && (off != 2'd0));
        r   = mis ? 1'b0 : io;
      end
    end
    return {d, i, t, r, mis};
  endfunction

  // Drive one access, push its expectation, then pop/compare when output is valid.
  task automatic apply(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a);
    sb_t e;
    opcode = op;
    funct3 = f3;
    addr   = a;
    e.tag  = tag;
    e.exp  = model(op, f3, a);
    sb_q.push_back(e);
`ifdef MEMCTRL_OUTREG_EN
    @(posedge clk);
`endif
    #1;
    e = sb_q.pop_front();
    check(e.tag, {18'd0, dmem_en, imem_en, io_trans, io_recv, misaligned}, {18'd0, e.exp});
  endtask

  initial begin
    logic [6:0]  rop;
    logic [2:0]  rf3;
    logic [31:0] ra;
    logic [2:0]  st_f3 [6];
    st_f3[0] = 3'd0; st_f3[1] = 3'd1; st_f3[2] = 3'd2;
    st_f3[3] = 3'd3; st_f3[4] = 3'd6; st_f3[5] = 3'd7;

    rst_n = 1'b0; opcode = 7'd0; funct3 = 3'd0; addr = 32'd0; err_clear = 1'b0;
    #12;
    check("reset_err", {31'd0, err_sticky}, 32'd0);
    check("reset_outs", {18'd0, dmem_en, imem_en, io_trans, io_recv, misaligned}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    apply("lb_io",    T_LOAD,  3'd0, 32'h8000_0000);
    check("lb_io_recv", {31'd0, io_recv}, 32'd1);
    apply("lh_dmem",  T_LOAD,  3'd1, 32'h1000_0000);
    apply("lw_io",    T_LOAD,  3'd2, 32'h8000_0000);
    apply("lbu_dmem", T_LOAD,  3'd4, 32'h1000_0000);
    apply("lhu_dmem", T_LOAD,  3'd5, 32'h1000_0000);
    apply("ld_bad_f3", T_LOAD, 3'd3, 32'h8000_0000);
    apply("sb_io",    T_STORE, 3'd0, 32'h8000_0004);
    check("sb_io_trans", {28'd0, io_trans}, 32'hF);
    apply("sb_off3",  T_STORE, 3'd0, 32'h1000_0003);
    check("sb_off3_dmem", {28'd0, dmem_en}, 32'h8);
    apply("sh_off2",  T_STORE, 3'd1, 32'h1000_0002);
    check("sh_off2_dmem", {28'd0, dmem_en}, 32'hC);
    apply("sw_both",  T_STORE, 3'd2, 32'h3000_0000);
    check("sw_both_imem", {28'd0, imem_en}, 32'hF);
    apply("sb_imem1", T_STORE, 3'd0, 32'h2000_0001);
    apply("other_op", 7'b0110011, 3'd0, 32'h9000_0000);
    check("no_err_yet", {31'd0, err_sticky}, 32'd0);

    apply("sw_mis",   T_STORE, 3'd2, 32'h1000_0002);
    check("sw_mis_flag", {31'd0, misaligned}, 32'd1);
    @(posedge clk); #1;
    check("err_set", {31'd0, err_sticky}, 32'd1);
    opcode = 7'd0;
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    check("err_clear", {31'd0, err_sticky}, 32'd0);
    opcode = T_LOAD; funct3 = 3'd1; addr = 32'h1000_0001;
    err_clear = 1'b1;
    @(posedge clk); #1;
    check("clear_prio", {31'd0, err_sticky}, 32'd0);
    err_clear = 1'b0;
    @(posedge clk); #1;
    check("lh_mis_err", {31'd0, err_sticky}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_err", {31'd0, err_sticky}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    opcode = 7'd0;
    @(posedge clk); #1;

    for (int k = 0; k < 40; k++) begin
      rop = ($urandom_range(0, 1) == 0) ? T_LOAD : T_STORE;
      rf3 = (rop == T_STORE) ? st_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      ra  = $urandom;
      apply("rand", rop, rf3, ra);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
